// File: rtl/bf_pkg.sv
// Shared state encoding and opcode bytes for the Brainfuck execution core.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package bf_pkg;

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_EXEC,
      ST_SEEK_FWD,
      ST_SEEK_BWD,
      ST_HALT
   } bf_state_e;

   localparam logic [7:0] OP_INC   = 8'h2B;
   localparam logic [7:0] OP_DEC   = 8'h2D;
   localparam logic [7:0] OP_RIGHT = 8'h3E;
   localparam logic [7:0] OP_LEFT  = 8'h3C;
   localparam logic [7:0] OP_OUT   = 8'h2E;
   localparam logic [7:0] OP_IN    = 8'h2C;
   localparam logic [7:0] OP_LOOP  = 8'h5B;
   localparam logic [7:0] OP_END   = 8'h5D;
   localparam logic [7:0] OP_NULL  = 8'h00;

endpackage

// File: rtl/bf_loop_stack.sv
// LIFO of loop-start addresses; top is combinational, push/pop take effect on the clock edge.
// Latency: 1 cycle push/pop, 0 cycles top/full/empty.
// Backpressure: push while full and pop while empty are ignored.
module bf_loop_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             full,
   output logic             empty
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [2**IDX_W];
   logic [CNT_W-1:0] count;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;

   // rd_idx = wr_idx-1 stays correct when count==DEPTH wraps the low bits
   assign wr_idx = count[IDX_W-1:0];
   assign rd_idx = wr_idx - IDX_W'(1);
   assign full   = (count == CNT_W'(DEPTH));
   assign empty  = (count == '0);
   assign top    = empty ? '0 : mem[rd_idx];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + CNT_W'(1);
      end else if (pop && !empty) begin
         count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (push && !full) begin
         mem[wr_idx] <= push_data;
      end
   end

endmodule

// File: rtl/bf_core.sv
// Brainfuck core: clears data RAM, then executes one opcode per cycle; BF_LOOP_STACK_EN adds a loop-return stack.
// Latency: 2^DATA_ADDR_SIZE clear cycles, then 1 cycle per opcode or seek step.
// Backpressure: '.' stalls until out_ready, ',' stalls until in_valid.
module bf_core import bf_pkg::*; #(
   parameter int PROG_ADDR_SIZE = 8,
   parameter int DATA_ADDR_SIZE = 8,
   parameter int CELL_WIDTH     = 8,
   parameter int STACK_DEPTH    = 8,
   parameter int DEPTH_WIDTH    = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   output logic [PROG_ADDR_SIZE-1:0] ip,
   input  logic [7:0]                instruction,
   output logic [DATA_ADDR_SIZE-1:0] cursor,
   input  logic [CELL_WIDTH-1:0]     read_val,
   output logic [CELL_WIDTH-1:0]     write_val,
   output logic                      write_enable,
   output logic [CELL_WIDTH-1:0]     out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   input  logic [CELL_WIDTH-1:0]     in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic                      halted,
   output logic                      error
);

   bf_state_e                 state, state_nxt;
   logic [PROG_ADDR_SIZE-1:0] ip_nxt, ip_inc, ip_dec;
   logic [DATA_ADDR_SIZE-1:0] cursor_nxt;
   logic [DEPTH_WIDTH-1:0]    depth, depth_nxt, depth_inc;
   logic                      error_nxt;
   logic                      we_int, ov_int, ir_int;
   logic [CELL_WIDTH-1:0]     wval_int;
   logic                      taken;

   assign ip_inc    = ip + PROG_ADDR_SIZE'(1);
   assign ip_dec    = ip - PROG_ADDR_SIZE'(1);
   assign depth_inc = (depth == '1) ? depth : depth + DEPTH_WIDTH'(1);
   assign taken     = (read_val != '0);

`ifdef BF_LOOP_STACK_EN
   logic [DEPTH_WIDTH-1:0]    spill, spill_nxt;
   logic                      stk_push, stk_pop, stk_full, stk_empty;
   logic [PROG_ADDR_SIZE-1:0] stk_top;

   bf_loop_stack #(
      .WIDTH (PROG_ADDR_SIZE),
      .DEPTH (STACK_DEPTH)
   ) u_loop_stack (
      .clock     (clock),
      .reset     (reset),
      .push      (stk_push),
      .pop       (stk_pop),
      .push_data (ip),
      .top       (stk_top),
      .full      (stk_full),
      .empty     (stk_empty)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) spill <= '0;
      else        spill <= spill_nxt;
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= ST_CLEAR;
         ip     <= '0;
         cursor <= '0;
         depth  <= '0;
         error  <= 1'b0;
      end else begin
         state  <= state_nxt;
         ip     <= ip_nxt;
         cursor <= cursor_nxt;
         depth  <= depth_nxt;
         error  <= error_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      ip_nxt     = ip;
      cursor_nxt = cursor;
      depth_nxt  = depth;
      error_nxt  = error;
      we_int     = 1'b0;
      wval_int   = '0;
      ov_int     = 1'b0;
      ir_int     = 1'b0;
`ifdef BF_LOOP_STACK_EN
      stk_push   = 1'b0;
      stk_pop    = 1'b0;
      spill_nxt  = spill;
`endif
      case (state)
         ST_CLEAR: begin
            we_int     = 1'b1;
            cursor_nxt = cursor + DATA_ADDR_SIZE'(1);
            if (cursor == '1) begin
               state_nxt = ST_EXEC;
               ip_nxt    = '0;
            end
         end
         ST_EXEC: begin
            case (instruction)
               OP_RIGHT: begin
                  cursor_nxt = cursor + DATA_ADDR_SIZE'(1);
                  ip_nxt     = ip_inc;
               end
               OP_LEFT: begin
                  cursor_nxt = cursor - DATA_ADDR_SIZE'(1);
                  ip_nxt     = ip_inc;
               end
               OP_INC: begin
                  we_int   = 1'b1;
                  wval_int = read_val + CELL_WIDTH'(1);
                  ip_nxt   = ip_inc;
               end
               OP_DEC: begin
                  we_int   = 1'b1;
                  wval_int = read_val - CELL_WIDTH'(1);
                  ip_nxt   = ip_inc;
               end
               OP_OUT: begin
                  ov_int = 1'b1;
                  if (out_ready) ip_nxt = ip_inc;
               end
               OP_IN: begin
                  ir_int = 1'b1;
                  if (in_valid) begin
                     we_int   = 1'b1;
                     wval_int = in_data;
                     ip_nxt   = ip_inc;
                  end
               end
               OP_LOOP: begin
                  ip_nxt = ip_inc;
                  if (!taken) begin
                     depth_nxt = '0;
                     state_nxt = ST_SEEK_FWD;
                  end
`ifdef BF_LOOP_STACK_EN
                  else if (!stk_full) begin
                     stk_push = 1'b1;
                  end else begin
                     spill_nxt = (spill == '1) ? spill : spill + DEPTH_WIDTH'(1);
                  end
`endif
               end
               OP_END: begin
                  ip_nxt = ip_inc;
`ifdef BF_LOOP_STACK_EN
                  if (spill == '0 && !stk_empty) begin
                     if (taken) ip_nxt = stk_top + PROG_ADDR_SIZE'(1);
                     else       stk_pop = 1'b1;
                  end else if (!taken && spill != '0) begin
                     spill_nxt = spill - DEPTH_WIDTH'(1);
                  end else if (taken) begin
`else
                  if (taken) begin
`endif
                     // a taken ']' at address 0 has nothing behind it to match
                     if (ip == '0) begin
                        error_nxt = 1'b1;
                        state_nxt = ST_HALT;
                     end else begin
                        depth_nxt = '0;
                        ip_nxt    = ip_dec;
                        state_nxt = ST_SEEK_BWD;
                     end
                  end
               end
               OP_NULL: state_nxt = ST_HALT;
               default: ip_nxt = ip_inc;
            endcase
         end
         ST_SEEK_FWD: begin
            ip_nxt = ip_inc;
            case (instruction)
               OP_LOOP: depth_nxt = depth_inc;
               OP_END: begin
                  if (depth == '0) state_nxt = ST_EXEC;
                  else             depth_nxt = depth - DEPTH_WIDTH'(1);
               end
               OP_NULL: begin
                  ip_nxt    = ip;
                  error_nxt = 1'b1;
                  state_nxt = ST_HALT;
               end
               default: ;
            endcase
         end
         ST_SEEK_BWD: begin
            // resuming after '[' skips its push: the loop re-enters the spill region
            if (instruction == OP_LOOP && depth == '0) begin
               ip_nxt    = ip_inc;
               state_nxt = ST_EXEC;
            end else if (instruction == OP_NULL || ip == '0) begin
               error_nxt = 1'b1;
               state_nxt = ST_HALT;
            end else begin
               ip_nxt = ip_dec;
               if (instruction == OP_LOOP)     depth_nxt = depth - DEPTH_WIDTH'(1);
               else if (instruction == OP_END) depth_nxt = depth_inc;
            end
         end
         default: ;
      endcase
   end

   assign write_enable = we_int & reset;
   assign write_val    = reset ? wval_int : '0;
   assign out_valid    = ov_int & reset;
   assign out_data     = (ov_int && reset) ? read_val : '0;
   assign in_ready     = ir_int & reset;
   assign halted       = (state == ST_HALT) && reset;

endmodule
